// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ds_pkg
// Brief    : Command codes, BCD masks, state encoding and sequencing helpers
//            for the DS1302 time sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ds_pkg;

    localparam logic [7:0] CMD_NONE      = 8'h00;
    localparam logic [7:0] CMD_WR_UNPROT = 8'h80;
    localparam logic [7:0] CMD_WR_HR     = 8'h40;
    localparam logic [7:0] CMD_WR_MIN    = 8'h20;
    localparam logic [7:0] CMD_WR_SEC    = 8'h10;
    localparam logic [7:0] CMD_WR_PROT   = 8'h08;
    localparam logic [7:0] CMD_RD_HR     = 8'h04;
    localparam logic [7:0] CMD_RD_MIN    = 8'h02;
    localparam logic [7:0] CMD_RD_SEC    = 8'h01;

    localparam logic [7:0] MASK_HOUR     = 8'h3F;
    localparam logic [7:0] MASK_MIN_SEC  = 8'h7F;

    localparam int         ST_W          = 4;
    localparam logic [3:0] ST_BOOT       = 4'd0;
    localparam logic [3:0] ST_INIT_UNP   = 4'd1;
    localparam logic [3:0] ST_INIT_HR    = 4'd2;
    localparam logic [3:0] ST_INIT_MIN   = 4'd3;
    localparam logic [3:0] ST_INIT_SEC   = 4'd4;
    localparam logic [3:0] ST_INIT_PROT  = 4'd5;
    localparam logic [3:0] ST_RD_HR      = 4'd6;
    localparam logic [3:0] ST_RD_MIN     = 4'd7;
    localparam logic [3:0] ST_RD_SEC     = 4'd8;
    localparam logic [3:0] ST_WAIT       = 4'd9;

    localparam logic       PH_ISSUE      = 1'b0;
    localparam logic       PH_GAP        = 1'b1;

    function automatic logic [7:0] cmd_for_state(input logic [3:0] st);
        case (st)
            ST_INIT_UNP:  cmd_for_state = CMD_WR_UNPROT;
            ST_INIT_HR:   cmd_for_state = CMD_WR_HR;
            ST_INIT_MIN:  cmd_for_state = CMD_WR_MIN;
            ST_INIT_SEC:  cmd_for_state = CMD_WR_SEC;
            ST_INIT_PROT: cmd_for_state = CMD_WR_PROT;
            ST_RD_HR:     cmd_for_state = CMD_RD_HR;
            ST_RD_MIN:    cmd_for_state = CMD_RD_MIN;
            ST_RD_SEC:    cmd_for_state = CMD_RD_SEC;
            default:      cmd_for_state = CMD_NONE;
        endcase
    endfunction

    // Successor after a command completes normally; RD_SEC is resolved by the caller.
    function automatic logic [3:0] seq_next(input logic [3:0] st);
        case (st)
            ST_INIT_UNP:  seq_next = ST_INIT_HR;
            ST_INIT_HR:   seq_next = ST_INIT_MIN;
            ST_INIT_MIN:  seq_next = ST_INIT_SEC;
            ST_INIT_SEC:  seq_next = ST_INIT_PROT;
            ST_INIT_PROT: seq_next = ST_RD_HR;
            ST_RD_HR:     seq_next = ST_RD_MIN;
            ST_RD_MIN:    seq_next = ST_RD_SEC;
            default:      seq_next = ST_WAIT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ds_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : ds_cycle_timer
// Brief    : Up-counter 0..MAX_COUNT-1 with synchronous clear; holds and flags
//            terminal count until cleared.
// Revision : 1.0 - initial release
// ============================================================================
module ds_cycle_timer #(
    parameter int MAX_COUNT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int             c_w    = $clog2(MAX_COUNT);
    localparam logic [c_w-1:0] c_last = c_w'(MAX_COUNT - 1);

    logic [c_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + c_w'(1);
        end
    end

    assign o_tc = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/ds_time_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ds_time_sequencer
// Brief    : Issues DS1302 one-hot commands, polls hh:mm:ss into BCD registers.
//            Optional DS_INIT_WRITE_EN macro enables the boot clock-set sequence.
// Revision : 1.0 - initial release
// ============================================================================
module ds_time_sequencer
    import ds_pkg::*;
#(
    parameter int POLL_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int GAP_CYCLES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] cmd,
    input  logic       cmd_done,
    input  logic [7:0] rd_data,
    input  logic       refresh_req,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       time_valid,
    output logic       busy,
    output logic       err_timeout
);

    localparam int                 c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);
`ifdef DS_INIT_WRITE_EN
    localparam logic [ST_W-1:0]    c_first_st = ST_INIT_UNP;
`else
    localparam logic [ST_W-1:0]    c_first_st = ST_RD_HR;
`endif

    logic [ST_W-1:0]    r_state;
    logic               r_phase;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic [7:0]         r_cmd;
    logic [7:0]         r_hour;
    logic [7:0]         r_minute;
    logic [7:0]         r_second;
    logic               r_time_valid;
    logic               r_err_timeout;
    logic               r_pending;

    logic               w_in_issue;
    logic               w_pend_now;
    logic               w_poll_tc;
    logic               w_timeout_tc;
    logic [ST_W-1:0]    w_after_gap;

    assign w_in_issue  = (r_phase == PH_ISSUE) && (r_state != ST_BOOT) && (r_state != ST_WAIT);
    assign w_pend_now  = r_pending | refresh_req;
    assign w_after_gap = (r_state == ST_RD_SEC) ? (w_pend_now ? ST_RD_HR : ST_WAIT)
                                                : seq_next(r_state);

    ds_cycle_timer #(.MAX_COUNT(POLL_CYCLES)) u_poll_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state != ST_WAIT),
        .i_en  (1'b1),
        .o_tc  (w_poll_tc)
    );

    ds_cycle_timer #(.MAX_COUNT(TIMEOUT_CYCLES)) u_timeout_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_in_issue),
        .i_en  (1'b1),
        .o_tc  (w_timeout_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_phase       <= PH_ISSUE;
            r_gap_cnt     <= '0;
            r_cmd         <= CMD_NONE;
            r_hour        <= 8'h00;
            r_minute      <= 8'h00;
            r_second      <= 8'h00;
            r_time_valid  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            r_time_valid <= 1'b0;
            // Requests outside WAIT collapse into one pending burst.
            if (refresh_req && (r_state != ST_WAIT)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_BOOT: begin
                    r_state <= c_first_st;
                    r_phase <= PH_ISSUE;
                    r_cmd   <= cmd_for_state(c_first_st);
                end
                ST_WAIT: begin
                    if (w_pend_now || w_poll_tc) begin
                        r_state   <= ST_RD_HR;
                        r_phase   <= PH_ISSUE;
                        r_cmd     <= CMD_RD_HR;
                        r_pending <= 1'b0;
                    end
                end
                default: begin
                    if (r_phase == PH_ISSUE) begin
                        if (cmd_done) begin
                            r_cmd     <= CMD_NONE;
                            r_phase   <= PH_GAP;
                            r_gap_cnt <= '0;
                            if (r_state == ST_RD_HR) begin
                                r_hour <= rd_data & MASK_HOUR;
                            end else if (r_state == ST_RD_MIN) begin
                                r_minute <= rd_data & MASK_MIN_SEC;
                            end else if (r_state == ST_RD_SEC) begin
                                r_second     <= rd_data & MASK_MIN_SEC;
                                r_time_valid <= 1'b1;
                            end
                        end else if (w_timeout_tc) begin
                            r_cmd         <= CMD_NONE;
                            r_err_timeout <= 1'b1;
                            r_state       <= ST_WAIT;
                        end
                    end else if (r_gap_cnt == c_gap_last) begin
                        r_state <= w_after_gap;
                        r_phase <= PH_ISSUE;
                        r_cmd   <= cmd_for_state(w_after_gap);
                        if ((r_state == ST_RD_SEC) && w_pend_now) begin
                            r_pending <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
                    end
                end
            endcase
        end
    end

    assign cmd         = r_cmd;
    assign hour        = r_hour;
    assign minute      = r_minute;
    assign second      = r_second;
    assign time_valid  = r_time_valid;
    assign err_timeout = r_err_timeout;
    assign busy        = (r_state != ST_WAIT) && (r_state != ST_BOOT);

endmodule
`default_nettype wire
